// File: rtl/pipe_pkg.sv
//============================================================================
// Module : pipe_pkg
// Brief  : Shared widths, control-field offsets and entry opcodes for the
//          pipeline stage registers.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package pipe_pkg;

    localparam int IFID_CTRL_W  = 4;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 12;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 12;
    localparam int EXMEM_DATA_W = 96;
    localparam int MEWB_CTRL_W  = 12;
    localparam int MEWB_DATA_W  = 64;

    // Control vector layout: [0] RegWrite, [1] MemWrite, [2] MemtoReg,
    // [6:3] Type, [11:7] WriteReg.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMTOREG = 2;
    localparam int CTRL_TYPE_LSB = 3;
    localparam int CTRL_WREG_LSB = 7;

    typedef enum logic [1:0] {
        ENT_HOLD      = 2'd0,
        ENT_LOAD_IN   = 2'd1,
        ENT_LOAD_SKID = 2'd2,
        ENT_CLEAR     = 2'd3
    } ent_op_e;

endpackage

`default_nettype wire

// File: rtl/pipe_entry_reg.sv
//============================================================================
// Module : pipe_entry_reg
// Brief  : One valid+ctrl+data pipeline entry with load/clear and bubble
//          zeroing of the control bits.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module pipe_entry_reg #(
    parameter int CTRL_W              = 12,
    parameter int DATA_W              = 64,
    parameter int ZERO_DATA_ON_BUBBLE = 0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Load,
    input  logic              Clear,
    input  logic [CTRL_W-1:0] LdCtrl,
    input  logic [DATA_W-1:0] LdData,
    output logic              Valid,
    output logic [CTRL_W-1:0] Ctrl,
    output logic [DATA_W-1:0] Data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (Clear) begin
            // An invalid entry must never carry live control bits.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (ZERO_DATA_ON_BUBBLE != 0) begin
                r_data <= '0;
            end
        end else if (Load) begin
            r_valid <= 1'b1;
            r_ctrl  <= LdCtrl;
            r_data  <= LdData;
        end
    end

    assign Valid = r_valid;
    assign Ctrl  = r_ctrl;
    assign Data  = r_data;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
//============================================================================
// Module : pipe_stage_skid_reg
// Brief  : Valid/ready pipeline stage with 2-entry skid buffer, flush,
//          bubble squashing and a saturating stall counter.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W              = MEWB_DATA_W,
    parameter int CTRL_W              = MEWB_CTRL_W,
    parameter int ZERO_DATA_ON_BUBBLE = 0,
    parameter int CNT_W               = 8
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [CTRL_W-1:0] InCtrl,
    input  logic [DATA_W-1:0] InData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [DATA_W-1:0] OutData,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  StallCnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic              w_m_valid;
    logic [CTRL_W-1:0] w_m_ctrl;
    logic [DATA_W-1:0] w_m_data;
    logic              w_s_valid;
    logic [CTRL_W-1:0] w_s_ctrl;
    logic [DATA_W-1:0] w_s_data;

    logic              w_in_fire;
    logic              w_out_fire;
    ent_op_e           w_m_op;
    ent_op_e           w_s_op;
    logic              w_m_valid_nxt;
    logic              w_s_valid_nxt;
    logic [CTRL_W-1:0] w_m_ld_ctrl;
    logic [DATA_W-1:0] w_m_ld_data;

    logic              r_in_ready;
    logic [1:0]        r_occupancy;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_in_fire  = InValid & r_in_ready;
    assign w_out_fire = w_m_valid & OutReady;

    always_comb begin
        w_m_op = ENT_HOLD;
        w_s_op = ENT_HOLD;
        if (Flush) begin
            w_m_op = ENT_CLEAR;
            w_s_op = ENT_CLEAR;
        end else if (!w_m_valid) begin
            if (w_in_fire) begin
                w_m_op = ENT_LOAD_IN;
            end
        end else if (w_out_fire) begin
            if (w_s_valid) begin
                w_m_op = ENT_LOAD_SKID;
                w_s_op = ENT_CLEAR;
            end else if (w_in_fire) begin
                w_m_op = ENT_LOAD_IN;
            end else begin
                w_m_op = ENT_CLEAR;
            end
        end else if (w_in_fire) begin
            w_s_op = ENT_LOAD_IN;
        end
    end

    always_comb begin
        w_m_valid_nxt = w_m_valid;
        w_s_valid_nxt = w_s_valid;
        if (w_m_op == ENT_CLEAR) begin
            w_m_valid_nxt = 1'b0;
        end else if (w_m_op != ENT_HOLD) begin
            w_m_valid_nxt = 1'b1;
        end
        if (w_s_op == ENT_CLEAR) begin
            w_s_valid_nxt = 1'b0;
        end else if (w_s_op != ENT_HOLD) begin
            w_s_valid_nxt = 1'b1;
        end
    end

    assign w_m_ld_ctrl = (w_m_op == ENT_LOAD_SKID) ? w_s_ctrl : InCtrl;
    assign w_m_ld_data = (w_m_op == ENT_LOAD_SKID) ? w_s_data : InData;

    pipe_entry_reg #(
        .CTRL_W              (CTRL_W),
        .DATA_W              (DATA_W),
        .ZERO_DATA_ON_BUBBLE (ZERO_DATA_ON_BUBBLE)
    ) u_main (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Load   ((w_m_op == ENT_LOAD_IN) || (w_m_op == ENT_LOAD_SKID)),
        .Clear  (w_m_op == ENT_CLEAR),
        .LdCtrl (w_m_ld_ctrl),
        .LdData (w_m_ld_data),
        .Valid  (w_m_valid),
        .Ctrl   (w_m_ctrl),
        .Data   (w_m_data)
    );

    pipe_entry_reg #(
        .CTRL_W              (CTRL_W),
        .DATA_W              (DATA_W),
        .ZERO_DATA_ON_BUBBLE (ZERO_DATA_ON_BUBBLE)
    ) u_skid (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Load   (w_s_op == ENT_LOAD_IN),
        .Clear  (w_s_op == ENT_CLEAR),
        .LdCtrl (InCtrl),
        .LdData (InData),
        .Valid  (w_s_valid),
        .Ctrl   (w_s_ctrl),
        .Data   (w_s_data)
    );

    // Ready and occupancy are registered from next-state so neither has a
    // combinational path from OutReady.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_in_ready  <= 1'b1;
            r_occupancy <= 2'd0;
            r_stall_cnt <= '0;
        end else begin
            r_in_ready  <= ~w_s_valid_nxt;
            r_occupancy <= {w_m_valid_nxt & w_s_valid_nxt, w_m_valid_nxt ^ w_s_valid_nxt};
            if (Flush) begin
                r_stall_cnt <= '0;
            end else if (w_m_valid && !OutReady && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign InReady   = r_in_ready;
    assign OutValid  = w_m_valid;
    assign OutCtrl   = w_m_ctrl;
    assign OutData   = w_m_data;
    assign Occupancy = r_occupancy;
    assign StallCnt  = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
//============================================================================
// Module : tb_pipe_stage_skid_reg
// Brief  : Directed + random bench for pipe_stage_skid_reg, both bubble-data
//          modes, against a queue-based reference model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_pipe_stage_skid_reg;

    localparam int c_CW  = 12;
    localparam int c_DW  = 64;
    localparam int c_NW  = 4;
    localparam int c_MAX = 15;

    typedef struct {
        logic [c_CW-1:0] c;
        logic [c_DW-1:0] d;
    } ent_t;

    logic            Clk = 1'b0;
    logic            Rst_n, Flush, InValid, OutReady;
    logic [c_CW-1:0] InCtrl;
    logic [c_DW-1:0] InData;

    logic            rdy0, rdy1, ov0, ov1;
    logic [c_CW-1:0] oc0, oc1;
    logic [c_DW-1:0] od0, od1;
    logic [1:0]      occ0, occ1;
    logic [c_NW-1:0] cnt0, cnt1;

    int n_total = 0;
    int n_bad   = 0;

    ent_t            q[$];
    int              m_cnt;
    logic [c_DW-1:0] m_last;

    always #5 Clk = ~Clk;

    pipe_stage_skid_reg #(.DATA_W(c_DW), .CTRL_W(c_CW), .ZERO_DATA_ON_BUBBLE(0), .CNT_W(c_NW)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(rdy0),
        .InCtrl(InCtrl), .InData(InData), .OutValid(ov0), .OutReady(OutReady),
        .OutCtrl(oc0), .OutData(od0), .Occupancy(occ0), .StallCnt(cnt0)
    );

    pipe_stage_skid_reg #(.DATA_W(c_DW), .CTRL_W(c_CW), .ZERO_DATA_ON_BUBBLE(1), .CNT_W(c_NW)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush), .InValid(InValid), .InReady(rdy1),
        .InCtrl(InCtrl), .InData(InData), .OutValid(ov1), .OutReady(OutReady),
        .OutCtrl(oc1), .OutData(od1), .Occupancy(occ1), .StallCnt(cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic rstn, input logic fl, input logic iv,
                        input logic [c_CW-1:0] ic, input logic [c_DW-1:0] id,
                        input logic ordy);
        bit   m_rdy, m_ov;
        ent_t e;
        logic [c_CW-1:0] ec;
        logic [c_DW-1:0] ed0, ed1;
        Rst_n = rstn; Flush = fl; InValid = iv; InCtrl = ic; InData = id; OutReady = ordy;
        m_rdy = (q.size() < 2);
        m_ov  = (q.size() > 0);
        if (!rstn) begin
            q.delete();
            m_cnt  = 0;
            m_last = '0;
        end else if (fl) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (m_ov && !ordy && m_cnt < c_MAX) m_cnt++;
            if (m_ov && ordy) void'(q.pop_front());
            if (iv && m_rdy) begin
                e.c = ic;
                e.d = id;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_last = q[0].d;

        @(posedge Clk);
        #1;
        ec  = (q.size() > 0) ? q[0].c : '0;
        ed0 = (q.size() > 0) ? q[0].d : m_last;
        ed1 = (q.size() > 0) ? q[0].d : '0;
        check("valid0", 64'(ov0),  64'(q.size() > 0));
        check("valid1", 64'(ov1),  64'(q.size() > 0));
        check("ctrl0",  64'(oc0),  64'(ec));
        check("ctrl1",  64'(oc1),  64'(ec));
        check("data0",  od0,       ed0);
        check("data1",  od1,       ed1);
        check("ready0", 64'(rdy0), 64'(q.size() < 2));
        check("ready1", 64'(rdy1), 64'(q.size() < 2));
        check("occ0",   64'(occ0), 64'(q.size()));
        check("occ1",   64'(occ1), 64'(q.size()));
        check("stall0", 64'(cnt0), 64'(m_cnt));
        check("stall1", 64'(cnt1), 64'(m_cnt));
    endtask

    initial begin
        q.delete();
        m_cnt  = 0;
        m_last = '0;

        // Reset with an offered entry that must be ignored
        step(0, 0, 1, 12'hABC, 64'hDEAD, 1);
        step(0, 0, 1, 12'hABC, 64'hDEAD, 1);
        check("rst_ready", 64'(rdy0), 64'd1);

        // Streaming at full throughput
        for (int i = 1; i <= 5; i++)
            step(1, 0, 1, c_CW'(i), 64'(i * 64'h1111), 1);
        step(1, 0, 0, '0, '0, 1);
        step(1, 0, 0, '0, '0, 1);

        // Backpressure: A held, B skids, C refused until drain
        step(1, 0, 1, 12'h0A1, 64'hA, 0);
        step(1, 0, 1, 12'h0B2, 64'hB, 0);
        step(1, 0, 1, 12'h0C3, 64'hC, 0);
        step(1, 0, 1, 12'h0C3, 64'hC, 0);
        check("bp_held", 64'(oc0), 64'h0A1);
        step(1, 0, 1, 12'h0C3, 64'hC, 1);
        step(1, 0, 1, 12'h0C3, 64'hC, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0, 1);

        // Flush with full skid, new entry D offered in the same cycle
        step(1, 0, 1, 12'h0A1, 64'hA, 0);
        step(1, 0, 1, 12'h0B2, 64'hB, 0);
        step(1, 1, 1, 12'h0D4, 64'hD, 0);
        check("flush_occ", 64'(occ0), 64'd0);
        step(1, 0, 0, '0, '0, 1);
        step(1, 0, 0, '0, '0, 1);

        // Bubble squash after an all-ones control word
        step(1, 0, 1, 12'hFFF, 64'h1234_5678_9ABC_DEF0, 1);
        step(1, 0, 0, '0, '0, 1);
        step(1, 0, 0, '0, '0, 1);
        check("bubble_data0", od0, 64'h1234_5678_9ABC_DEF0);
        check("bubble_data1", od1, 64'h0);

        // Stall counter saturation
        step(1, 0, 1, 12'h055, 64'h55, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, '0, '0, 0);
        check("sat", 64'(cnt0), 64'd15);
        step(1, 1, 0, '0, '0, 0);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            logic rstn, fl, iv, ordy;
            rstn = ($urandom_range(0, 299) != 0);
            fl   = ($urandom_range(0, 59) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(rstn, fl, iv, c_CW'($urandom), {$urandom, $urandom}, ordy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline stage register, the next generation of the fixed-field stage registers between pipeline stages (e.g. MEM->WB). It carries one generic control vector and one data vector, and uses a valid/ready handshake with a 2-entry skid buffer so stalls propagate without combinational ready paths. It also supports synchronous flush, bubble squashing of control bits and a saturating stall counter for debug. All pipeline boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB) instantiate it with different widths.

Parameters:
DATA_W, 64, payload width (e.g. Result and ReadDM concatenated)
CTRL_W, 12, control width (RegWrite, MemWrite, MemtoReg, Type, WriteReg...); forced to 0 in bubbles
ZERO_DATA_ON_BUBBLE, 0, 1 = data register also cleared whenever its entry is invalid; 0 = data holds its last value
CNT_W, 8, stall counter width

Ports:
Clk  in  1  clock, all state updates on posedge
Rst_n  in  1  reset
Flush  in  1  synchronous kill of all held entries
InValid  in  1  upstream entry valid
InReady  out  1  stage can accept; registered
InCtrl  in  CTRL_W  upstream control
InData  in  DATA_W  upstream payload
OutValid  out  1  downstream entry valid
OutReady  in  1  downstream accepts
OutCtrl  out  CTRL_W  control of head entry, 0 when OutValid=0
OutData  out  DATA_W  payload of head entry
Occupancy  out  2  entries held, 0..2
StallCnt  out  CNT_W  cycles with OutValid & !OutReady, saturating

Behaviour:
- Interface: one clock (Clk); reset Rst_n is synchronous and active-low.
- Storage: main entry M (drives the Out* ports) plus skid entry S; each has a valid bit, CTRL_W control bits and DATA_W data bits.
- Reset (Rst_n=0 at posedge): M and S invalid, all ctrl/data 0, StallCnt 0. Resulting outputs: OutValid=0, OutCtrl=0, OutData=0, InReady=1, Occupancy=0.
- Fires: in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- InReady = !S.valid. It depends only on registered state; there is no combinational path from OutReady.
- Update rules at posedge, priority order: Rst_n, then Flush, then data movement.
  - Flush=1: M and S invalid, ctrl zeroed. A same-cycle in_fire is dropped. StallCnt cleared. Data cleared only if ZERO_DATA_ON_BUBBLE=1.
  - M empty: if in_fire, M <= input.
  - M full and out_fire: if S valid, M <= S and S becomes invalid; otherwise, if in_fire, M <= input; otherwise M becomes invalid.
  - M full, no out_fire, in_fire: S <= input, so InReady=0 next cycle.
  - S valid implies InReady=0, so in_fire and S-valid never coincide.
- Latency: 1 cycle from in_fire to OutValid when empty. Throughput: 1 entry/cycle with OutReady held high. Order is strictly FIFO (M before S).
- Bubble: whenever an entry becomes invalid, its ctrl is written 0, so RegWrite/MemWrite can never leak from a bubble. Data follows ZERO_DATA_ON_BUBBLE.
- Occupancy = M.valid + S.valid, registered.
- StallCnt: +1 each cycle OutValid & !OutReady, saturates at 2^CNT_W-1, never wraps. Cleared on reset and on Flush.
- Reset or Flush mid-stall: everything is discarded in one cycle. No partial entry survives. InReady=1 the following cycle.

Decomposition:
- Shared package pipe_pkg holds the per-boundary width constants (MEWB_CTRL_W, MEWB_DATA_W, etc.) and the ctrl-field bit offsets (CTRL_REGWRITE, CTRL_MEMWRITE, CTRL_MEMTOREG, CTRL_TYPE_LSB, CTRL_WREG_LSB).
- One natural sub-module: pipe_entry_reg, a single valid+ctrl+data register with load/clear enables and bubble zeroing, instantiated twice (M, S).

Test Plan:
- Reset: hold Rst_n=0 with InValid=1, InData=0xDEAD -> OutValid=0, OutCtrl=0, OutData=0, InReady=1, Occupancy=0 after the posedge.
- Streaming: OutReady=1, push ctrl 0x001..0x005 on 5 consecutive cycles -> each appears on OutCtrl exactly 1 cycle later, in order, InReady stays 1, StallCnt=0.
- Backpressure: OutReady=0, push A, B, C -> A held at output, B in skid, InReady=0 after B, C not accepted. StallCnt counts 1,2,3... Raise OutReady -> A, B, then C out in order.
- Flush with full skid: M=A, S=B, Flush=1 with InValid=1 (D) -> next cycle OutValid=0, OutCtrl=0, Occupancy=0, StallCnt=0, InReady=1, D never appears.
- Bubble squash: push ctrl 0xFFF, then InValid=0 with OutReady=1 -> after drain OutCtrl=0. OutData is 0 with ZERO_DATA_ON_BUBBLE=1, and retains the last payload with ZERO_DATA_ON_BUBBLE=0.
- Saturation: CNT_W=4, stall 20 cycles -> StallCnt stops at 15.
